// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the transmitter and the baud counter.
package uart_pkg;

  localparam int   UART_DATA_W    = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // PARITY exists in every build; it is only reachable with UART_TX_PARITY_EN.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and flags the last count.
module uart_baud_cnt #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick_o = (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      r_cnt <= '0;
    end else if (tick_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per valid/ready handshake, sent as 8N1 (8E1 when
// UART_TX_PARITY_EN is defined), LSB first, with a registered tx_o.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_tick;
  logic              w_accept;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (r_state != IDLE),
    .tick_o (w_tick)
  );

  assign ready_o  = (r_state == IDLE);
  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == STOP) && w_tick;
  assign tx_o     = r_tx;
  assign w_accept = valid_i && ready_o;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_shift_nxt = data_i;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_tick) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line level is chosen from the next state so the flop output lines up with it.
  always_comb begin
    w_tx_nxt = UART_IDLE_LVL;
    unique case (w_state_nxt)
      START:   w_tx_nxt = UART_START_LVL;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = r_parity;
`endif
      default: w_tx_nxt = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= 3'd0;
      r_tx      <= UART_IDLE_LVL;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^data_i;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a per-cycle scoreboard of expected tx/done/ready
// values is filled as bytes are offered and drained on each falling edge.
module tb_uart_tx_frame;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_A = NBITS * DIV_A;
  localparam int FRAME_B = NBITS * DIV_B;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, valid_a, ready_a, tx_a, busy_a, done_a;
  logic [7:0] data_a;
  logic       rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
  logic [7:0] data_b;

  uart_tx_frame #(.CLK_DIV(DIV_A), .DATA_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
  );

  uart_tx_frame #(.CLK_DIV(DIV_B), .DATA_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
  );

  typedef struct packed {
    logic tx;
    logic done;
    logic ready;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back('{tx: 1'b1, done: 1'b0, ready: 1'b1});
  endtask

  task automatic push_frame(input logic [7:0] b, input int div);
    logic lvl;
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)           lvl = 1'b0;
      else if (k <= 8)      lvl = b[k-1];
      else if (NBITS == 11 && k == 9) lvl = ^b;
      else                  lvl = 1'b1;
      for (int c = 0; c < div; c++)
        sb_q.push_back('{tx: lvl, done: (k == NBITS - 1) && (c == div - 1), ready: 1'b0});
    end
  endtask

  task automatic check(input int sel, input int n, input string tag);
    exp_t e;
    logic o_tx, o_done, o_ready, o_busy;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o_tx    = (sel == 0) ? tx_a    : tx_b;
      o_done  = (sel == 0) ? done_a  : done_b;
      o_ready = (sel == 0) ? ready_a : ready_b;
      o_busy  = (sel == 0) ? busy_a  : busy_b;
      n_vec++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL %s scoreboard empty at step %0d (got tx %b, want an entry)", tag, i, o_tx);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        assert (o_tx === e.tx) else begin
          n_err++; $error("FAIL %s tx step %0d got %b want %b", tag, i, o_tx, e.tx);
        end
        n_vec++;
        assert (o_done === e.done) else begin
          n_err++; $error("FAIL %s done step %0d got %b want %b", tag, i, o_done, e.done);
        end
        n_vec++;
        assert (o_ready === e.ready) else begin
          n_err++; $error("FAIL %s ready step %0d got %b want %b", tag, i, o_ready, e.ready);
        end
        n_vec++;
        assert (o_busy === !e.ready) else begin
          n_err++; $error("FAIL %s busy step %0d got %b want %b", tag, i, o_busy, !e.ready);
        end
      end
    end
  endtask

  task automatic send_a(input logic [7:0] b, input string tag);
    valid_a = 1'b1;
    data_a  = b;
    push_frame(b, DIV_A);
    push_idle(1);
    check(0, 1, tag);
    valid_a = 1'b0;
    data_a  = 8'h00;
    check(0, FRAME_A, tag);
  endtask

  initial begin
    rst_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
    rst_b = 1'b1; valid_b = 1'b0; data_b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state held while idle
    push_idle(20);
    check(0, 20, "reset_idle");

    // Single byte A5
    send_a(8'hA5, "frame_a5");

    // Back-to-back 00 then FF with valid held and data changed mid-frame
    valid_a = 1'b1;
    data_a  = 8'h00;
    push_frame(8'h00, DIV_A);
    push_idle(1);
    push_frame(8'hFF, DIV_A);
    push_idle(2);
    check(0, 10, "b2b_00");
    data_a = 8'h55;
    check(0, 20, "b2b_00");
    data_a = 8'hFF;
    check(0, FRAME_A + 1 - 30, "b2b_gap");
    check(0, 1, "b2b_ff_start");
    valid_a = 1'b0;
    check(0, FRAME_A - 1, "b2b_ff");
    check(0, 2, "b2b_idle");

    // Reset mid-frame, then a clean frame
    valid_a = 1'b1;
    data_a  = 8'hC3;
    push_frame(8'hC3, DIV_A);
    check(0, 1, "abort_pre");
    valid_a = 1'b0;
    check(0, 16, "abort_pre");
    sb_q.delete();
    push_idle(1);
    rst_a = 1'b1;
    check(0, 1, "abort_reset");
    rst_a = 1'b0;
    push_idle(2);
    check(0, 2, "abort_idle");
    send_a(8'h3C, "frame_3c");

    // Fast divider instance, byte 01
    valid_b = 1'b1;
    data_b  = 8'h01;
    push_frame(8'h01, DIV_B);
    push_idle(1);
    check(1, 1, "div2_01");
    valid_b = 1'b0;
    check(1, FRAME_B, "div2_01");

`ifdef UART_TX_PARITY_EN
    send_a(8'h07, "parity_07");
    send_a(8'h03, "parity_03");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter: serialises one byte per handshake into an 8N1 frame on tx_o: start bit (0), 8 data bits LSB first, stop bit (1).
- Counterpart of the team's shift-register UART receiver.
- Sits between the byte source (CPU/FIFO side) and the TX pin.
- Contains its own bit-period counter; no external baud clock is needed.

Parameters:
- CLK_DIV, 16: clk_i cycles per bit period; legal range 2..65535.
- DATA_W, 8: data bits per frame; fixed at 8 in this release.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  8  byte to send; sampled only on an accepted handshake.
- valid_i  input  1  byte on data_i is valid.
- ready_o  output  1  transmitter can accept a byte (IDLE state only).
- tx_o  output  1  serial line; idles high; registered output.
- busy_o  output  1  frame in progress (any state other than IDLE).
- done_o  output  1  one-cycle pulse in the last clk_i cycle of the stop bit.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - tx_o=1, ready_o=1, busy_o=0, done_o=0.
  - State IDLE, bit counter 0, divider counter 0, shift register 0.
  - Reset mid-frame aborts the frame. tx_o is 1 from the next edge on. A truncated frame is acceptable.
- Handshake:
  - Accept occurs at an edge where valid_i=1 and ready_o=1.
  - data_i is copied into the shift register at that edge. Later changes of data_i have no effect on the frame.
  - valid_i while busy is ignored. There is no queueing, and no ready_o combinational path from valid_i.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_o=1. On accept, go to START and clear the divider.
  - START: tx_o=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for CLK_DIV cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles. done_o=1 in the final cycle. Then go to IDLE.
- Timing:
  - tx_o falls in the cycle after the accept edge (latency 1).
  - Each bit lasts exactly CLK_DIV cycles.
  - A frame lasts 10*CLK_DIV cycles.
  - ready_o rises in the cycle after done_o.
  - Minimum start-to-start spacing is 10*CLK_DIV+1 cycles.
- Divider:
  - Width is $clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1. Bit advances when the count equals CLK_DIV-1; the count then wraps to 0.
  - Held at 0 in IDLE.
- Bit index: 3 bits, 0..7. No wrap beyond 7; the state changes instead.
- done_o and ready_o are never high in the same cycle.
- tx_o is glitch-free: it is driven from a flop, never decoded combinationally from state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_o = XOR of the 8 accepted data bits (even parity) for CLK_DIV cycles.
  - Frame is 11*CLK_DIV cycles; minimum spacing is 11*CLK_DIV+1 cycles.
  - The parity bit is computed at accept time and stored in a flop.
- Undefined:
  - No PARITY state, no parity flop.
  - 8N1 timing exactly as above.

Decomposition:
- Package uart_pkg:
  - Typedef tx_state_t enum {IDLE, START, DATA, PARITY, STOP}. PARITY is present regardless of the macro and is unreachable when the macro is disabled.
  - Constants UART_DATA_W=8, UART_IDLE_LVL=1'b1, UART_START_LVL=1'b0.
- Sub-module uart_baud_cnt:
  - Parameter CLK_DIV.
  - Inputs clk_i, rst_i, en_i. Output tick_o, high in count CLK_DIV-1.
  - Counter clears when en_i=0.
  - Reusable later by the receiver rework.

Test Plan (CLK_DIV=4 unless noted):
1. Reset -> tx_o=1, ready_o=1, busy_o=0, done_o=0; hold 20 cycles -> no change.
2. Accept 8'hA5 -> tx_o sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. done_o pulses at cycle 40 after accept. ready_o=1 at cycle 41.
3. valid_i held high with 8'h00 then 8'hFF back-to-back -> second start bit begins exactly 41 cycles after the first. Bytes are not merged. data_i change mid-frame is ignored.
4. rst_i asserted at cycle 17 of a frame (DATA) -> tx_o=1, ready_o=1 next cycle. A new accept of 8'h3C produces a full correct frame.
5. CLK_DIV=2, byte 8'h01 -> start is 2 cycles low, bit0 is 2 cycles high, total frame 20 cycles.
6. UART_TX_PARITY_EN defined:
   - 8'h07 -> parity bit 1; frame 44 cycles; done_o at cycle 44.
   - 8'h03 -> parity bit 0.
